// File: rtl/primitive_assembly_pkg.sv
// Shared opcodes, FSM/mode encodings and vertex bit-slice positions for primitive_assembly.
// Opcode values must stay in step with global_def.h.
package primitive_assembly_pkg;

    localparam logic [7:0] OP_NOP            = 8'h00;
    localparam logic [7:0] OP_SETVERTEX      = 8'h30;
    localparam logic [7:0] OP_SETCOLOR       = 8'h31;
    localparam logic [7:0] OP_ROTATE         = 8'h32;
    localparam logic [7:0] OP_TRANSLATE      = 8'h33;
    localparam logic [7:0] OP_SCALE          = 8'h34;
    localparam logic [7:0] OP_PUSHMATRIX     = 8'h35;
    localparam logic [7:0] OP_POPMATRIX      = 8'h36;
    localparam logic [7:0] OP_BEGINPRIMITIVE = 8'h37;
    localparam logic [7:0] OP_ENDPRIMITIVE   = 8'h38;
    localparam logic [7:0] OP_LOADIDENTITY   = 8'h39;
    localparam logic [7:0] OP_FLUSH          = 8'h3A;

    // x lives in VOut[31:16], y in VOut[47:32]
    localparam int VERTEX_X_LSB = 16;
    localparam int VERTEX_Y_LSB = 32;

    typedef enum logic {ST_IDLE = 1'b0, ST_COLLECT = 1'b1} state_t;
    typedef enum logic {MODE_LIST = 1'b0, MODE_STRIP = 1'b1} mode_t;

endpackage

// File: rtl/primitive_assembly_prim_out_reg.sv
// Triangle holding register facing the rasterizer, with consume logic and a
// saturating count of consumed triangles. Updates on the falling clock edge.
module prim_out_reg #(
    parameter int COORD_WIDTH = 16,
    parameter int VREG_WIDTH  = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [2*COORD_WIDTH-1:0] load_v0,
    input  logic [2*COORD_WIDTH-1:0] load_v1,
    input  logic [2*COORD_WIDTH-1:0] load_v2,
    input  logic [VREG_WIDTH-1:0]    load_color,
    input  logic                     rast_ready,
    output logic                     tri_valid,
    output logic [2*COORD_WIDTH-1:0] tri_v0,
    output logic [2*COORD_WIDTH-1:0] tri_v1,
    output logic [2*COORD_WIDTH-1:0] tri_v2,
    output logic [VREG_WIDTH-1:0]    tri_color,
    output logic [CNT_WIDTH-1:0]     tri_count
);

    // Handshake: a triangle transfers on any edge where tri_valid and rast_ready are
    // both 1; once tri_valid rises the fields hold until that transfer, and a load on
    // the transfer edge replaces the triangle without dropping tri_valid.
    logic consume;
    assign consume = tri_valid & rast_ready;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            tri_valid <= 1'b0;
            tri_v0    <= '0;
            tri_v1    <= '0;
            tri_v2    <= '0;
            tri_color <= '0;
            tri_count <= '0;
        end else begin
            if (load) begin
                tri_valid <= 1'b1;
                tri_v0    <= load_v0;
                tri_v1    <= load_v1;
                tri_v2    <= load_v2;
                tri_color <= load_color;
            end else if (consume) begin
                tri_valid <= 1'b0;
            end
            if (consume && (tri_count != {CNT_WIDTH{1'b1}})) begin
                tri_count <= tri_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/primitive_assembly.sv
// Groups vertices between BEGIN/END primitive opcodes into triangles for the rasterizer.
// Strip assembly is built only when PRIMITIVE_ASSEMBLY_STRIP_EN is defined; otherwise always list.
module primitive_assembly
    import primitive_assembly_pkg::*;
#(
    parameter int OPCODE_WIDTH = 8,
    parameter int VREG_WIDTH   = 64,
    parameter int COORD_WIDTH  = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET,
    input  logic                     I_LOCK,
    input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
    input  logic [VREG_WIDTH-1:0]    I_VIn,
    input  logic [VREG_WIDTH-1:0]    I_ColorIn,
    input  logic                     I_RastReady,
    output logic                     O_FRAMESTALL,
    output logic                     O_LOCK,
    output logic                     O_TriValid,
    output logic [2*COORD_WIDTH-1:0] O_TriV0,
    output logic [2*COORD_WIDTH-1:0] O_TriV1,
    output logic [2*COORD_WIDTH-1:0] O_TriV2,
    output logic [VREG_WIDTH-1:0]    O_TriColor,
    output logic [CNT_WIDTH-1:0]     O_TriCount,
    output logic                     dbg_state
);

    localparam int VW = 2 * COORD_WIDTH;

    state_t          state, state_n;
    mode_t           mode, mode_n, begin_mode;
    logic [1:0]      vcnt, vcnt_n;
    logic            parity, parity_n;
    logic [VW-1:0]   slot0, slot1, slot0_n, slot1_n;
    logic [VW-1:0]   vertex;
    logic [VW-1:0]   ld_v0, ld_v1, ld_v2;
    logic            load;
    logic            accept;
    logic            unused_vin;

    assign O_LOCK       = I_LOCK;
    assign O_FRAMESTALL = O_TriValid & ~I_RastReady;
    assign accept       = I_LOCK & ~O_FRAMESTALL;
    assign dbg_state    = state;
    assign vertex       = {I_VIn[VERTEX_Y_LSB +: COORD_WIDTH], I_VIn[VERTEX_X_LSB +: COORD_WIDTH]};
    assign unused_vin   = ^I_VIn;

`ifdef PRIMITIVE_ASSEMBLY_STRIP_EN
    assign begin_mode = mode_t'(I_VIn[0]);
`else
    assign begin_mode = MODE_LIST;
`endif

    // The third vertex of a triangle is never stored: it feeds the output register
    // directly, so two slots plus the incoming vertex form the three-vertex window.
    always_comb begin
        state_n  = state;
        mode_n   = mode;
        vcnt_n   = vcnt;
        parity_n = parity;
        slot0_n  = slot0;
        slot1_n  = slot1;
        ld_v0    = slot0;
        ld_v1    = slot1;
        ld_v2    = vertex;
        load     = 1'b0;
        if (accept) begin
            case (I_Opcode)
                OP_BEGINPRIMITIVE: begin
                    state_n  = ST_COLLECT;
                    mode_n   = begin_mode;
                    vcnt_n   = 2'd0;
                    parity_n = 1'b0;
                end
                OP_ENDPRIMITIVE, OP_FLUSH: begin
                    state_n = ST_IDLE;
                    vcnt_n  = 2'd0;
                end
                OP_SETVERTEX: begin
                    if (state == ST_COLLECT) begin
                        if (vcnt == 2'd0) begin
                            slot0_n = vertex;
                            vcnt_n  = 2'd1;
                        end else if (vcnt == 2'd1) begin
                            slot1_n = vertex;
                            vcnt_n  = 2'd2;
                        end else begin
                            load = 1'b1;
                            if (mode == MODE_STRIP) begin
                                // odd strip triangles swap the older pair to keep winding
                                if (parity) begin
                                    ld_v0 = slot1;
                                    ld_v1 = slot0;
                                end
                                slot0_n  = slot1;
                                slot1_n  = vertex;
                                parity_n = ~parity;
                            end else begin
                                vcnt_n = 2'd0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            state  <= ST_IDLE;
            mode   <= MODE_LIST;
            vcnt   <= 2'd0;
            parity <= 1'b0;
            slot0  <= '0;
            slot1  <= '0;
        end else begin
            state  <= state_n;
            mode   <= mode_n;
            vcnt   <= vcnt_n;
            parity <= parity_n;
            slot0  <= slot0_n;
            slot1  <= slot1_n;
        end
    end

    prim_out_reg #(
        .COORD_WIDTH (COORD_WIDTH),
        .VREG_WIDTH  (VREG_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_out (
        .clk        (I_CLOCK),
        .rst        (I_RESET),
        .load       (load),
        .load_v0    (ld_v0),
        .load_v1    (ld_v1),
        .load_v2    (ld_v2),
        .load_color (I_ColorIn),
        .rast_ready (I_RastReady),
        .tri_valid  (O_TriValid),
        .tri_v0     (O_TriV0),
        .tri_v1     (O_TriV1),
        .tri_v2     (O_TriV2),
        .tri_color  (O_TriColor),
        .tri_count  (O_TriCount)
    );

endmodule

// File: tb/tb_primitive_assembly.sv
// Directed bench for primitive_assembly with a triangle scoreboard; a second instance
// with a 2-bit counter exercises counter saturation on the same stimulus.
module tb_primitive_assembly;
    import primitive_assembly_pkg::*;

    localparam int TW = 160;

    logic        I_CLOCK = 1'b0;
    logic        I_RESET;
    logic        I_LOCK;
    logic [7:0]  I_Opcode;
    logic [63:0] I_VIn;
    logic [63:0] I_ColorIn;
    logic        I_RastReady;

    logic        O_FRAMESTALL, O_LOCK, O_TriValid, dbg_state;
    logic [31:0] O_TriV0, O_TriV1, O_TriV2;
    logic [63:0] O_TriColor;
    logic [15:0] O_TriCount;

    logic        sat_stall, sat_lock, sat_valid, sat_state;
    logic [31:0] sat_v0, sat_v1, sat_v2;
    logic [63:0] sat_color;
    logic [1:0]  sat_count;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] mon_exp;
    logic [TW-1:0] held;

    primitive_assembly dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_Opcode(I_Opcode),
        .I_VIn(I_VIn), .I_ColorIn(I_ColorIn), .I_RastReady(I_RastReady),
        .O_FRAMESTALL(O_FRAMESTALL), .O_LOCK(O_LOCK), .O_TriValid(O_TriValid),
        .O_TriV0(O_TriV0), .O_TriV1(O_TriV1), .O_TriV2(O_TriV2),
        .O_TriColor(O_TriColor), .O_TriCount(O_TriCount), .dbg_state(dbg_state)
    );

    primitive_assembly #(.CNT_WIDTH(2)) dut_sat (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_Opcode(I_Opcode),
        .I_VIn(I_VIn), .I_ColorIn(I_ColorIn), .I_RastReady(I_RastReady),
        .O_FRAMESTALL(sat_stall), .O_LOCK(sat_lock), .O_TriValid(sat_valid),
        .O_TriV0(sat_v0), .O_TriV1(sat_v1), .O_TriV2(sat_v2),
        .O_TriColor(sat_color), .O_TriCount(sat_count), .dbg_state(sat_state)
    );

    // clock / reset: state changes on the falling edge
    always #5 I_CLOCK = ~I_CLOCK;

    function automatic logic [63:0] mkv(input int x, input int y, input logic m);
        mkv = {16'hA5A5, y[15:0], x[15:0], 15'h0, m};
    endfunction

    function automatic logic [31:0] pv(input int x, input int y);
        pv = {y[15:0], x[15:0]};
    endfunction

    function automatic logic [TW-1:0] mk_tri(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [63:0] col);
        mk_tri = {a, b, c, col};
    endfunction

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_count(input string tag);
        chk({tag, "_count"}, TW'(O_TriCount), TW'(exp_count));
        chk({tag, "_satcount"}, TW'(sat_count), TW'((exp_count > 3) ? 3 : exp_count));
    endtask

    // driver tasks: inputs change 2 time units after the falling edge
    task automatic cyc(input logic [7:0] op, input logic [63:0] vin, input logic [63:0] col,
                       input logic lock);
        I_Opcode  = op;
        I_VIn     = vin;
        I_ColorIn = col;
        I_LOCK    = lock;
        @(negedge I_CLOCK);
        #2;
    endtask

    task automatic vtx(input int x, input int y, input logic [63:0] col);
        cyc(OP_SETVERTEX, mkv(x, y, 1'b0), col, 1'b1);
    endtask

    task automatic begin_prim(input logic m);
        cyc(OP_BEGINPRIMITIVE, mkv(0, 0, m), 64'h0, 1'b1);
    endtask

    task automatic nop();
        cyc(OP_NOP, 64'h0, 64'h0, 1'b1);
    endtask

    // scoreboard: a triangle seen valid+ready before the falling edge is consumed on it
    always @(posedge I_CLOCK) begin
        if (!I_RESET && O_TriValid && I_RastReady) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_tri observed=%0h expected=none",
                       {O_TriV0, O_TriV1, O_TriV2, O_TriColor});
            end
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                chk("tri_fields", {O_TriV0, O_TriV1, O_TriV2, O_TriColor}, mon_exp);
            end
            exp_count++;
        end
    end

    initial begin
        I_RESET = 1'b1; I_LOCK = 1'b0; I_Opcode = OP_NOP;
        I_VIn = '0; I_ColorIn = '0; I_RastReady = 1'b1;
        repeat (2) @(negedge I_CLOCK);
        #2;
        chk("rst_valid", TW'(O_TriValid), TW'(0));
        chk("rst_fields", {O_TriV0, O_TriV1, O_TriV2, O_TriColor}, '0);
        chk("rst_state", TW'(dbg_state), TW'(ST_IDLE));
        chk("rst_stall", TW'(O_FRAMESTALL), TW'(0));
        chk_count("rst");
        I_RESET = 1'b0;

        // list triangle, rasterizer ready
        begin_prim(1'b0);
        chk("begin_state", TW'(dbg_state), TW'(ST_COLLECT));
        vtx(1, 2, 64'hAAAA_0000_0000_000A);
        vtx(3, 4, 64'hBBBB_0000_0000_000B);
        chk("list_not_early", TW'(O_TriValid), TW'(0));
        exp_q.push_back(mk_tri(pv(1, 2), pv(3, 4), pv(5, 6), 64'hCCCC_0000_0000_000C));
        vtx(5, 6, 64'hCCCC_0000_0000_000C);
        chk("list_valid", TW'(O_TriValid), TW'(1));
        chk("list_direct", {O_TriV0, O_TriV1, O_TriV2, O_TriColor},
            mk_tri(pv(1, 2), pv(3, 4), pv(5, 6), 64'hCCCC_0000_0000_000C));
        chk("lock_pass", TW'(O_LOCK), TW'(1));
        nop();
        chk("list_consumed", TW'(O_TriValid), TW'(0));
        chk_count("list");

        // asynchronous reset in the middle of a primitive
        begin_prim(1'b0);
        vtx(7, 8, 64'h1);
        vtx(9, 10, 64'h2);
        #1 I_RESET = 1'b1;
        #1;
        exp_count = 0;
        chk("mid_rst_state", TW'(dbg_state), TW'(ST_IDLE));
        chk("mid_rst_fields", {O_TriV0, O_TriV1, O_TriV2, O_TriColor}, '0);
        chk_count("mid_rst");
        @(negedge I_CLOCK);
        #2 I_RESET = 1'b0;
        vtx(11, 11, 64'h3);
        vtx(12, 12, 64'h4);
        vtx(13, 13, 64'h5);
        chk("idle_vtx_ignored", TW'(O_TriValid), TW'(0));
        chk("idle_state", TW'(dbg_state), TW'(ST_IDLE));

        // back-pressure: stalled edges accept nothing and fields hold
        I_RastReady = 1'b0;
        begin_prim(1'b0);
        vtx(11, 12, 64'h11);
        vtx(13, 14, 64'h12);
        held = mk_tri(pv(11, 12), pv(13, 14), pv(15, 16), 64'h13);
        exp_q.push_back(held);
        vtx(15, 16, 64'h13);
        for (int i = 0; i < 3; i++) begin
            chk("bp_stall", TW'(O_FRAMESTALL), TW'(1));
            chk("bp_hold", {O_TriV0, O_TriV1, O_TriV2, O_TriColor}, held);
            vtx(17, 18, 64'h14);
        end
        chk_count("bp_stalled");
        I_RastReady = 1'b1;
        vtx(17, 18, 64'h14);
        chk("bp_released", TW'(O_TriValid), TW'(0));
        chk("bp_stall_drop", TW'(O_FRAMESTALL), TW'(0));
        chk_count("bp");
        vtx(19, 20, 64'h15);
        exp_q.push_back(mk_tri(pv(17, 18), pv(19, 20), pv(21, 22), 64'h16));
        vtx(21, 22, 64'h16);
        chk("bp_next_valid", TW'(O_TriValid), TW'(1));
        nop();

        // partial primitive discarded by END
        begin_prim(1'b0);
        vtx(31, 32, 64'h21);
        vtx(33, 34, 64'h22);
        cyc(OP_ENDPRIMITIVE, 64'h0, 64'h0, 1'b1);
        chk("end_state", TW'(dbg_state), TW'(ST_IDLE));
        begin_prim(1'b0);
        vtx(35, 36, 64'h23);
        vtx(37, 38, 64'h24);
        exp_q.push_back(mk_tri(pv(35, 36), pv(37, 38), pv(39, 40), 64'h25));
        vtx(39, 40, 64'h25);
        nop();

        // restart by BEGIN, with unrelated opcodes interleaved
        begin_prim(1'b0);
        vtx(41, 42, 64'h31);
        begin_prim(1'b0);
        vtx(43, 44, 64'h32);
        cyc(OP_SETCOLOR, mkv(90, 91, 1'b0), 64'h77, 1'b1);
        cyc(OP_PUSHMATRIX, mkv(92, 93, 1'b0), 64'h78, 1'b1);
        vtx(45, 46, 64'h33);
        exp_q.push_back(mk_tri(pv(43, 44), pv(45, 46), pv(47, 48), 64'h34));
        vtx(47, 48, 64'h34);
        nop();

        // upstream not valid: vertex ignored
        begin_prim(1'b0);
        vtx(51, 52, 64'h41);
        cyc(OP_SETVERTEX, mkv(99, 99, 1'b0), 64'h99, 1'b0);
        chk("lock_low", TW'(O_LOCK), TW'(0));
        vtx(53, 54, 64'h42);
        exp_q.push_back(mk_tri(pv(51, 52), pv(53, 54), pv(55, 56), 64'h43));
        vtx(55, 56, 64'h43);
        nop();

        // flush drops partial vertices and returns to idle
        begin_prim(1'b0);
        vtx(57, 57, 64'h51);
        vtx(58, 58, 64'h52);
        cyc(OP_FLUSH, 64'h0, 64'h0, 1'b1);
        chk("flush_state", TW'(dbg_state), TW'(ST_IDLE));
        vtx(59, 59, 64'h53);
        chk("flush_no_tri", TW'(O_TriValid), TW'(0));

        // strip request: winding swapped on odd triangles when strips are built
        begin_prim(1'b1);
        vtx(61, 62, 64'h60);
        vtx(63, 64, 64'h61);
        exp_q.push_back(mk_tri(pv(61, 62), pv(63, 64), pv(65, 66), 64'h62));
        vtx(65, 66, 64'h62);
`ifdef PRIMITIVE_ASSEMBLY_STRIP_EN
        exp_q.push_back(mk_tri(pv(65, 66), pv(63, 64), pv(67, 68), 64'h63));
        vtx(67, 68, 64'h63);
        exp_q.push_back(mk_tri(pv(65, 66), pv(67, 68), pv(69, 70), 64'h64));
        vtx(69, 70, 64'h64);
        exp_q.push_back(mk_tri(pv(69, 70), pv(67, 68), pv(71, 72), 64'h65));
        vtx(71, 72, 64'h65);
`else
        vtx(67, 68, 64'h63);
        vtx(69, 70, 64'h64);
        chk("strip_off_pending", TW'(O_TriValid), TW'(0));
        exp_q.push_back(mk_tri(pv(67, 68), pv(69, 70), pv(71, 72), 64'h65));
        vtx(71, 72, 64'h65);
`endif
        cyc(OP_ENDPRIMITIVE, 64'h0, 64'h0, 1'b1);
        nop();
        nop();

        chk("queue_drained", TW'(exp_q.size()), TW'(0));
        chk("final_valid", TW'(O_TriValid), TW'(0));
        chk_count("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
